// File: rtl/timer_counter_hms.sv
// Run-time counter: divides the clock into ticks and accumulates packed-BCD HH:MM:SS,
// gated by a four-state IDLE/RUN/PAUSE/DONE controller. Requires TICK_DIV >= 2 and 2**PRE_W >= TICK_DIV.
module timer_counter_hms #(
   parameter int TICK_DIV = 100_000_000,
   parameter int PRE_W    = 27
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       fin,
   output logic [7:0] CcountH,
   output logic [7:0] CcountM,
   output logic [7:0] CcountS,
   output logic       en_cmp,
   output logic       running,
   output logic       done,
   output logic       tick
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [7:0]       h_q, h_d, m_q, m_d, s_q, s_d;
   logic             tick_q, tick_d;
   logic [7:0]       h_nx, m_nx, s_nx;

   // Two-digit BCD increment that wraps to 00 once the value reaches max.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      logic [3:0] tens, units;
      tens  = v[7:4];
      units = v[3:0];
      if (v == max)
         return 8'h00;
      else if (units == 4'd9)
         return {tens + 4'd1, 4'd0};
      else
         return {tens, units + 4'd1};
   endfunction

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      h_d     = h_q;
      m_d     = m_q;
      s_d     = s_q;
      tick_d  = 1'b0;
      h_nx    = bcd_inc(h_q, 8'h23);
      m_nx    = bcd_inc(m_q, 8'h59);
      s_nx    = bcd_inc(s_q, 8'h59);

      if (clear) begin
         state_d = S_IDLE;
         pre_d   = '0;
         h_d     = 8'h00;
         m_d     = 8'h00;
         s_d     = 8'h00;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) state_d = S_RUN;
            end
            S_RUN: begin
               // fin and stop both pre-empt a tick that falls due in the same cycle.
               if (fin) begin
                  state_d = S_DONE;
               end else if (stop) begin
                  state_d = S_PAUSE;
               end else if (pre_q == PRE_LAST) begin
                  pre_d  = '0;
                  tick_d = 1'b1;
                  s_d    = s_nx;
                  if (s_q == 8'h59) begin
                     m_d = m_nx;
                     if (m_q == 8'h59) h_d = h_nx;
                  end
               end else begin
                  pre_d = pre_q + PRE_W'(1);
               end
            end
            S_PAUSE: begin
               if (start) state_d = S_RUN;
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         h_q     <= 8'h00;
         m_q     <= 8'h00;
         s_q     <= 8'h00;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         h_q     <= h_d;
         m_q     <= m_d;
         s_q     <= s_d;
         tick_q  <= tick_d;
      end
   end

   assign CcountH = h_q;
   assign CcountM = m_q;
   assign CcountS = s_q;
   assign tick    = tick_q;
   assign running = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);
   assign en_cmp  = (state_q == S_RUN) || (state_q == S_DONE);

endmodule

// File: tb/tb_timer_counter_hms.sv
// Randomised and directed bench for timer_counter_hms; the reference model tracks
// elapsed time as an integer number of seconds and converts to BCD for comparison.
module tb_timer_counter_hms;

   localparam int TICK_DIV = 4;
   localparam int MS_IDLE  = 0;
   localparam int MS_RUN   = 1;
   localparam int MS_PAUSE = 2;
   localparam int MS_DONE  = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop  = 1'b0;
   logic       clear = 1'b0;
   logic       fin   = 1'b0;
   logic [7:0] CcountH, CcountM, CcountS;
   logic       en_cmp, running, done, tick;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_state = MS_IDLE;
   int m_pre   = 0;
   int m_secs  = 0;
   bit m_tick  = 1'b0;

   logic [7:0] pl_h, pl_m, pl_s;

   timer_counter_hms #(.TICK_DIV(TICK_DIV), .PRE_W(3)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .stop    (stop),
      .clear   (clear),
      .fin     (fin),
      .CcountH (CcountH),
      .CcountM (CcountM),
      .CcountS (CcountS),
      .en_cmp  (en_cmp),
      .running (running),
      .done    (done),
      .tick    (tick)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic model_step(input bit r, input bit c, input bit f, input bit sp, input bit st);
      m_tick = 1'b0;
      if (r) begin
         m_state = MS_IDLE;
         m_pre   = 0;
         m_secs  = 0;
      end else if (c) begin
         m_state = MS_IDLE;
         m_pre   = 0;
         m_secs  = 0;
      end else begin
         case (m_state)
            MS_IDLE:  if (st) m_state = MS_RUN;
            MS_PAUSE: if (st) m_state = MS_RUN;
            MS_RUN: begin
               if (f) m_state = MS_DONE;
               else if (sp) m_state = MS_PAUSE;
               else if (m_pre == TICK_DIV - 1) begin
                  m_pre  = 0;
                  m_secs = (m_secs + 1) % 86400;
                  m_tick = 1'b1;
               end else m_pre = m_pre + 1;
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare_all();
      check_eq("H", 32'(CcountH), 32'(bcd(m_secs / 3600)));
      check_eq("M", 32'(CcountM), 32'(bcd((m_secs / 60) % 60)));
      check_eq("S", 32'(CcountS), 32'(bcd(m_secs % 60)));
      check_eq("running", 32'(running), 32'(m_state == MS_RUN));
      check_eq("done", 32'(done), 32'(m_state == MS_DONE));
      check_eq("en_cmp", 32'(en_cmp), 32'(m_state == MS_RUN || m_state == MS_DONE));
      check_eq("tick", 32'(tick), 32'(m_tick));
   endtask

   task automatic step(input bit r, input bit c, input bit f, input bit sp, input bit st);
      @(negedge clock);
      reset = r; clear = c; fin = f; stop = sp; start = st;
      @(posedge clock);
      model_step(r, c, f, sp, st);
      #1;
      compare_all();
   endtask

   // Leaves the DUT paused at the given elapsed time with the prescaler at 0.
   task automatic preload(input int secs);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0);
      pl_h = bcd(secs / 3600);
      pl_m = bcd((secs / 60) % 60);
      pl_s = bcd(secs % 60);
      @(negedge clock);
      stop = 1'b0;
      force dut.h_q = pl_h;
      force dut.m_q = pl_m;
      force dut.s_q = pl_s;
      @(posedge clock);
      @(negedge clock);
      release dut.h_q;
      release dut.m_q;
      release dut.s_q;
      m_secs = secs;
      step(0, 0, 0, 0, 0);
   endtask

   task automatic run_wrap(input int secs, input logic [7:0] eh, input logic [7:0] em,
                           input logic [7:0] es);
      int k;
      preload(secs);
      step(0, 0, 0, 0, 1);
      k = 0;
      while (!m_tick && k < 2 * TICK_DIV) begin
         step(0, 0, 0, 0, 0);
         k++;
      end
      check_eq("wrap_tick", 32'(tick), 32'(1));
      check_eq("wrap_H", 32'(CcountH), 32'(eh));
      check_eq("wrap_M", 32'(CcountM), 32'(em));
      check_eq("wrap_S", 32'(CcountS), 32'(es));
   endtask

   initial begin
      int k;
      int lat;

      // reset state
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      // count three ticks from reset
      step(0, 0, 0, 0, 1);
      repeat (12) step(0, 0, 0, 0, 0);
      check_eq("t1_S", 32'(CcountS), 32'h03);
      check_eq("t1_running", 32'(running), 32'(1));
      check_eq("t1_en_cmp", 32'(en_cmp), 32'(1));

      // BCD carries and the day wrap
      run_wrap(59, 8'h00, 8'h01, 8'h00);
      run_wrap(3599, 8'h01, 8'h00, 8'h00);
      run_wrap(86399, 8'h00, 8'h00, 8'h00);

      // pause mid-prescale and resume
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      k = 0;
      while (m_pre != 2 && k < 10) begin
         step(0, 0, 0, 0, 0);
         k++;
      end
      step(0, 0, 0, 1, 0);
      repeat (20) step(0, 0, 0, 1, 0);
      check_eq("pause_running", 32'(running), 32'(0));
      step(0, 0, 0, 0, 1);
      lat = 0;
      while (tick !== 1'b1 && lat < 10) begin
         step(0, 0, 0, 0, 0);
         lat++;
      end
      check_eq("resume_lat", 32'(lat), 32'(2));

      // fin freezes the count in DONE
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      k = 0;
      while (m_secs != 5 && k < 40) begin
         step(0, 0, 0, 0, 0);
         k++;
      end
      step(0, 0, 1, 0, 0);
      check_eq("fin_done", 32'(done), 32'(1));
      repeat (50) step(0, 0, 1, 1'($urandom % 2), 1'($urandom % 2));
      check_eq("done_S", 32'(CcountS), 32'h05);
      check_eq("done_en_cmp", 32'(en_cmp), 32'(1));

      // clear out of DONE, then clear+start in RUN
      step(0, 1, 0, 0, 0);
      check_eq("clr_done", 32'(done), 32'(0));
      check_eq("clr_en_cmp", 32'(en_cmp), 32'(0));
      step(0, 0, 0, 0, 1);
      repeat (5) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1);
      check_eq("clr_start_running", 32'(running), 32'(0));
      check_eq("clr_start_S", 32'(CcountS), 32'h00);

      // reset while a tick is due at 00:02:17
      preload(137);
      step(0, 0, 0, 0, 1);
      k = 0;
      while (m_pre != TICK_DIV - 1 && k < 10) begin
         step(0, 0, 0, 0, 0);
         k++;
      end
      step(1, 0, 0, 0, 0);
      check_eq("rst_M", 32'(CcountM), 32'h00);
      check_eq("rst_S", 32'(CcountS), 32'h00);
      check_eq("rst_tick", 32'(tick), 32'(0));
      check_eq("rst_running", 32'(running), 32'(0));

      // random control traffic starting close to midnight
      preload(86390);
      for (int i = 0; i < 4000; i++) begin
         step(1'($urandom % 300 == 0), 1'($urandom % 60 == 0), 1'($urandom % 40 == 0),
              1'($urandom % 12 == 0), 1'($urandom % 4 == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
